sram_responder: RTL
===================

Name: sram_responder

Overview:
- Synthesizable and simulatable model of the external 16-bit asynchronous SRAM chip. It is the responder side of the SRAM pin interface that the memory-stage SRAM controller drives.
- Holds a word array with byte-lane write masking and answers reads on the bidirectional DQ bus after a configurable latency.
- Keeps read/write access counters and a sticky out-of-range error flag for bench observability.
- Used in system simulation and FPGA loopback builds in place of the physical chip.

Parameters:
- ADDR_W, 18, SRAM address width in bits.
- DATA_W, 16, DQ width in bits; fixed at 16 because there are two byte lanes.
- DEPTH, 262144, number of implemented words; must be ≤ 2^ADDR_W.
- READ_LATENCY, 0, cycles from address to DQ valid. 0 = asynchronous read; 1..4 = registered pipeline.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- SRAM_DQ  inout  16  data bus; driven only as specified under Behaviour, else high-Z.
- SRAM_ADDR  in  18  word address.
- SRAM_UB_N  in  1  high-byte lane enable (DQ[15:8]), active-low.
- SRAM_LB_N  in  1  low-byte lane enable (DQ[7:0]), active-low.
- SRAM_WE_N  in  1  write enable, active-low.
- SRAM_CE_N  in  1  chip enable, active-low.
- SRAM_OE_N  in  1  output enable, active-low.
- rd_count  out  32  number of read cycles accepted, saturating.
- wr_count  out  32  number of write cycles accepted, saturating.
- oor_err  out  1  sticky flag: an access with address ≥ DEPTH occurred.
- proto_err  out  1  sticky protocol-check flag; see Optional Feature.

Behaviour:
- Reset (async):
  - rd_count=0, wr_count=0, oor_err=0, proto_err=0.
  - Read pipeline valid bits cleared; DQ released to high-Z.
  - Memory array contents are NOT cleared.
- Cycle classification, evaluated at each rising clk edge from the pin values:
  - Write cycle: CE_N=0 and WE_N=0. WE_N overrides OE_N, so OE_N=0 during a write is legal.
  - Read cycle: CE_N=0, WE_N=1, OE_N=0.
  - Idle: anything else.
- Write:
  - At the clk edge, mem[ADDR][15:8] ← DQ[15:8] if UB_N=0.
  - mem[ADDR][7:0] ← DQ[7:0] if LB_N=0.
  - UB_N=LB_N=1 writes nothing but still counts as a write.
  - wr_count increments by 1, saturating at 32'hFFFFFFFF.
- Read, READ_LATENCY=0:
  - DQ driven combinationally with mem[ADDR] while the read condition is true.
  - Lanes whose UB_N/LB_N is 1 drive 8'hZZ.
  - rd_count increments once per clk edge at which the read condition holds.
- Read, READ_LATENCY=N≥1:
  - Shift pipeline of {valid, data, lane mask}, N stages deep. Stage 0 captures mem[ADDR] at the edge.
  - DQ is driven from the final stage while its valid=1 and OE_N=0; otherwise high-Z.
  - rd_count increments at capture.
- Ordering:
  - A write at edge k followed by a read of the same address at edge k+1 returns the new data.
  - Reads and writes can never overlap in the same cycle because write has precedence.
- Bus turnaround: the responder never drives DQ while WE_N=0 in the same cycle, including when stale pipeline data is valid. That data is discarded.
- Out of range (ADDR ≥ DEPTH):
  - Write is dropped.
  - Read returns 16'h0000.
  - oor_err is set to 1 and holds until reset.
  - The access is still counted.
- Reset asserted mid-access: pipeline is flushed, DQ goes high-Z immediately, any write at that edge is suppressed.
- Counters and flags change only on clk edges, never combinationally.

Optional Feature:
- Macro: SRAM_RESPONDER_PROTO_CHECK_EN.
- Defined: proto_err is set (sticky until reset) on any clk edge where a write cycle has an X/Z bit on ADDR or on an enabled DQ lane, or where CE_N/WE_N/OE_N is X/Z.
  - The offending write is dropped.
  - Under simulation, a $display message with time and address is emitted; this is excluded from synthesis.
- Undefined: proto_err is tied to 0 and there is no checking logic.

Test Plan:
- Reset, then write 16'hBEEF to addr 5 with UB_N=LB_N=0, then read addr 5 at latency 0 -> DQ=16'hBEEF in the same cycle; wr_count=1, rd_count=1.
- Write 16'h1234 to addr 9, then write 16'hAB00 with UB_N=0, LB_N=1 -> read returns 16'hAB34; with UB_N=1, LB_N=0 on read, DQ=16'hzz34.
- READ_LATENCY=2: issue reads to addr 0..3 holding 16'h0000..16'h0003 on consecutive cycles -> DQ shows 0,1,2,3 starting 2 cycles after the first address; high-Z when WE_N=0 is inserted mid-stream.
- DEPTH=1024: write to addr 1024, then read it -> DQ=16'h0000, oor_err=1 and stays 1 until rst; mem[0] unchanged.
- Assert rst during the second cycle of a latency-2 read -> DQ is high-Z the same cycle; counters=0; a prior write to addr 7 still reads back its old value after reset.
- With SRAM_RESPONDER_PROTO_CHECK_EN: write with DQ=16'hxx00 and LB_N=0, UB_N=0 -> proto_err=1 and the target word is unchanged. Without the macro, proto_err stays 0.

Source files
------------

// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - SRAM control/address pin bundle shared by the controller and the responder
interface sram_responder_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;
  logic              SRAM_WE_N;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;

  modport master (
    output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );

  modport slave (
    input SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );
endinterface

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - 16-bit asynchronous SRAM responder model with access counters
// Optional X/Z pin checking is enabled by defining SRAM_RESPONDER_PROTO_CHECK_EN.
module sram_responder #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 262144,
  parameter int READ_LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  sram_responder_if.slave   bus,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic              oor_err,
  output logic              proto_err
);
  localparam int HB = DATA_W / 2;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              is_write;
  logic              is_read;
  logic              in_range;
  logic              wr_ok;
  logic              proto_bad;
  logic [1:0]        lane_en;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] dq_out;
  logic [1:0]        dq_drv;

  // WE_N has priority over OE_N, so a read can never coincide with a write
  always_comb begin
    is_write = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
    is_read  = !bus.SRAM_CE_N && bus.SRAM_WE_N && !bus.SRAM_OE_N;
    in_range = {1'b0, bus.SRAM_ADDR} < DEPTH_LIM;
    lane_en  = {!bus.SRAM_UB_N, !bus.SRAM_LB_N};
    idx      = bus.SRAM_ADDR[IDX_W-1:0];
    rd_word  = in_range ? mem[idx] : '0;
  end

`ifdef SRAM_RESPONDER_PROTO_CHECK_EN
  assign proto_bad = $isunknown({bus.SRAM_CE_N, bus.SRAM_WE_N, bus.SRAM_OE_N}) ||
                     (is_write && ($isunknown(bus.SRAM_ADDR) ||
                                   (lane_en[1] && $isunknown(SRAM_DQ[DATA_W-1:HB])) ||
                                   (lane_en[0] && $isunknown(SRAM_DQ[HB-1:0]))));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) proto_err <= 1'b0;
    else if (proto_bad) proto_err <= 1'b1;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && proto_bad)
      $display("%t sram_responder: X/Z on control or write pins, addr %h", $time, bus.SRAM_ADDR);
  end
`endif
`else
  assign proto_bad = 1'b0;
  assign proto_err = 1'b0;
`endif

  assign wr_ok = is_write && in_range && !proto_bad && !rst;

  // Array is deliberately left uncleared by reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (lane_en[1]) mem[idx][DATA_W-1:HB] <= SRAM_DQ[DATA_W-1:HB];
      if (lane_en[0]) mem[idx][HB-1:0]      <= SRAM_DQ[HB-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
      oor_err  <= 1'b0;
    end else begin
      if (is_read && rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
      if (is_write && wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
      if ((is_read || is_write) && !in_range) oor_err <= 1'b1;
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_async
      assign dq_out = rd_word;
      assign dq_drv = (is_read && !rst) ? lane_en : 2'b00;
    end else begin : g_pipe
      logic [READ_LATENCY-1:0] p_valid;
      logic [DATA_W-1:0]       p_data [READ_LATENCY];
      logic [1:0]              p_lane [READ_LATENCY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_valid <= '0;
        end else begin
          p_valid[0] <= is_read;
          for (int i = 1; i < READ_LATENCY; i++) p_valid[i] <= p_valid[i-1];
        end
      end

      always_ff @(posedge clk) begin
        p_data[0] <= rd_word;
        p_lane[0] <= lane_en;
        for (int i = 1; i < READ_LATENCY; i++) begin
          p_data[i] <= p_data[i-1];
          p_lane[i] <= p_lane[i-1];
        end
      end

      // Stale pipeline data is dropped rather than fighting the controller during a write
      assign dq_out = p_data[READ_LATENCY-1];
      assign dq_drv = (p_valid[READ_LATENCY-1] && !bus.SRAM_OE_N && bus.SRAM_WE_N && !rst)
                      ? p_lane[READ_LATENCY-1] : 2'b00;
    end
  endgenerate

  assign SRAM_DQ[DATA_W-1:HB] = dq_drv[1] ? dq_out[DATA_W-1:HB] : {HB{1'bz}};
  assign SRAM_DQ[HB-1:0]      = dq_drv[0] ? dq_out[HB-1:0]      : {HB{1'bz}};
endmodule
